// File: rtl/indegree_pkg.sv
// Shared types for the in-degree table.
//   state_t : table lifecycle. CLEAR sweeps zeros into every entry, RUN serves ops.
//   op_t    : kind of operation held in the read-modify-write stage.
// Node and degree widths depend on module parameters, so each module declares
// its own node_t / degree_t typedefs locally.
package indegree_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef enum logic {
        OP_INC = 1'b0,
        OP_DEC = 1'b1
    } op_t;

endpackage

// File: rtl/indegree_table_ram.sv
// Degree storage: MAX_NODES x DEGREE_WIDTH, one write port, one registered read port.
// A read and a write to the same address in the same cycle returns the old
// contents. The table relies on that and forwards the newer value itself.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address, sampled every cycle
//   rdata_o  : read data, one cycle after raddr_i
module degree_ram
    import indegree_pkg::*;
#(
    parameter int MAX_NODES    = 1024,
    parameter int NODE_WIDTH   = $clog2(MAX_NODES),
    parameter int DEGREE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [NODE_WIDTH-1:0]   waddr_i,
    input  logic [DEGREE_WIDTH-1:0] wdata_i,
    input  logic [NODE_WIDTH-1:0]   raddr_i,
    output logic [DEGREE_WIDTH-1:0] rdata_o
);

    logic [DEGREE_WIDTH-1:0] mem_q [MAX_NODES];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/indegree_table.sv
// Per-node saturating in-degree counters for the topological-sort scheduler.
// Edge increments and node decrements arrive on ready/valid ports; each
// decrement returns its post-decrement degree one cycle after acceptance.
//   clk, rst_n        : clock, synchronous active-low reset
//   clear_req         : re-zero the whole table (honoured only in RUN)
//   init_done         : table valid, ports usable
//   inc_valid/node/ready : edge increment request
//   dec_valid/node/ready : node decrement request (wins over increment)
//   dec_resp_*        : decrement response, valid the cycle after acceptance
//   overflow/underflow: sticky saturation flags, cleared when a sweep starts
module indegree_table
    import indegree_pkg::*;
#(
    parameter int MAX_NODES    = 1024,
    parameter int NODE_WIDTH   = $clog2(MAX_NODES),
    parameter int DEGREE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_req,
    output logic                    init_done,
    input  logic                    inc_valid,
    input  logic [NODE_WIDTH-1:0]   inc_node,
    output logic                    inc_ready,
    input  logic                    dec_valid,
    input  logic [NODE_WIDTH-1:0]   dec_node,
    output logic                    dec_ready,
    output logic                    dec_resp_valid,
    output logic [NODE_WIDTH-1:0]   dec_resp_node,
    output logic [DEGREE_WIDTH-1:0] dec_resp_degree,
    output logic                    dec_resp_zero,
    output logic                    overflow,
    output logic                    underflow
);

    typedef logic [NODE_WIDTH-1:0]   node_t;
    typedef logic [DEGREE_WIDTH-1:0] degree_t;

    localparam degree_t DEG_MAX   = '1;
    localparam node_t   LAST_NODE = node_t'(MAX_NODES - 1);

    state_t  state_q;
    node_t   sweep_q;

    // Read-modify-write stage (stage 2)
    logic    s2_vld_q;
    op_t     s2_op_q;
    node_t   s2_node_q;

    // Last op write, for back-to-back forwarding
    logic    fwd_vld_q;
    node_t   fwd_node_q;
    degree_t fwd_data_q;

    logic    ovf_q, ovf_d;
    logic    unf_q, unf_d;

    logic    running;
    logic    dec_acc, inc_acc;
    node_t   rd_node;
    degree_t rd_data;
    degree_t base;
    degree_t new_deg;
    logic    sat_inc, sat_dec;
    logic    ram_we;
    node_t   ram_waddr;
    degree_t ram_wdata;

    assign running   = (state_q == RUN);
    assign dec_ready = running && !clear_req;
    assign inc_ready = running && !clear_req && !dec_valid;
    assign dec_acc   = dec_valid && dec_ready;
    assign inc_acc   = inc_valid && inc_ready;
    assign rd_node   = dec_acc ? dec_node : inc_node;

    // The RAM read issued alongside the previous op's write returns stale data,
    // so a stage-2 op on the same node takes the value that op just wrote.
    // Ops two or more cycles apart see the RAM already updated.
    always_comb begin
        base    = (fwd_vld_q && (fwd_node_q == s2_node_q)) ? fwd_data_q : rd_data;
        new_deg = base;
        sat_inc = 1'b0;
        sat_dec = 1'b0;
        if (s2_op_q == OP_INC) begin
            if (base == DEG_MAX) sat_inc = 1'b1;
            else                 new_deg = base + 1'b1;
        end else begin
            if (base == '0) sat_dec = 1'b1;
            else            new_deg = base - 1'b1;
        end
    end

    // No op is ever in stage 2 while CLEAR runs: an op accepted in RUN
    // always finishes before the sweep starts.
    always_comb begin
        ram_we    = !running || s2_vld_q;
        ram_waddr = running ? s2_node_q : sweep_q;
        ram_wdata = running ? new_deg : '0;
    end

    // Starting a sweep wipes the flags, even if the last op sets one.
    always_comb begin
        ovf_d = ovf_q || (s2_vld_q && sat_inc);
        unf_d = unf_q || (s2_vld_q && sat_dec);
        if (running && clear_req) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    degree_ram #(
        .MAX_NODES   (MAX_NODES),
        .NODE_WIDTH  (NODE_WIDTH),
        .DEGREE_WIDTH(DEGREE_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(rd_node),
        .rdata_o(rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            sweep_q    <= '0;
            s2_vld_q   <= 1'b0;
            s2_op_q    <= OP_INC;
            s2_node_q  <= '0;
            fwd_vld_q  <= 1'b0;
            fwd_node_q <= '0;
            fwd_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (sweep_q == LAST_NODE) state_q <= RUN;
                    else                      sweep_q <= sweep_q + 1'b1;
                end
                RUN: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        sweep_q <= '0;
                    end
                end
                default: state_q <= CLEAR;
            endcase

            s2_vld_q   <= dec_acc || inc_acc;
            s2_op_q    <= dec_acc ? OP_DEC : OP_INC;
            s2_node_q  <= rd_node;
            fwd_vld_q  <= s2_vld_q;
            fwd_node_q <= s2_node_q;
            fwd_data_q <= new_deg;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign init_done       = running;
    assign overflow        = ovf_q;
    assign underflow       = unf_q;
    assign dec_resp_valid  = s2_vld_q && (s2_op_q == OP_DEC);
    assign dec_resp_node   = dec_resp_valid ? s2_node_q : '0;
    assign dec_resp_degree = dec_resp_valid ? new_deg : '0;
    assign dec_resp_zero   = dec_resp_valid && (new_deg == '0);

endmodule

// File: doc/indegree_table.md
Name: indegree_table

Overview:
- Parametrised successor of the graph in-degree list used by the topological-sort path counter.
- Holds one saturating degree counter per node. Accepts edge increments and node decrements through ready/valid ports.
- Returns the post-decrement degree with a zero flag, so the scheduler can push newly-ready nodes.
- Adds a self-clearing sweep after reset and on request, forwarding between back-to-back read-modify-writes, independent degree width, and sticky overflow/underflow flags.

Parameters:
- MAX_NODES, 1024, number of table entries.
- NODE_WIDTH, $clog2(MAX_NODES), node index width.
- DEGREE_WIDTH, 8, counter width; saturates at 2**DEGREE_WIDTH-1.

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- clear_req  in  1  pulse: re-zero the whole table; sampled only in RUN
- init_done  out  1  high in RUN (table valid, ports usable)
- inc_valid  in  1  increment request
- inc_node  in  NODE_WIDTH  destination node of an edge
- inc_ready  out  1  increment accepted when inc_valid && inc_ready
- dec_valid  in  1  decrement request
- dec_node  in  NODE_WIDTH  node whose in-degree drops by one
- dec_ready  out  1  decrement accepted when dec_valid && dec_ready
- dec_resp_valid  out  1  one-cycle strobe per accepted decrement
- dec_resp_node  out  NODE_WIDTH  node of the response
- dec_resp_degree  out  DEGREE_WIDTH  degree after decrement
- dec_resp_zero  out  1  dec_resp_degree == 0
- overflow  out  1  sticky: increment hit the saturation value
- underflow  out  1  sticky: decrement of a zero entry

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to CLEAR with sweep address 0.
  - init_done, inc_ready, dec_ready, dec_resp_valid, overflow and underflow are all 0. dec_resp_node and dec_resp_degree are 0.
  - Pipeline valid bits are cleared. Reset mid-operation aborts the op: no write, no response.
- FSM CLEAR:
  - Writes 0 to one entry per cycle, addresses 0..MAX_NODES-1 in order.
  - After writing the last entry it moves to RUN. Entry into RUN is exactly MAX_NODES cycles after leaving reset.
- FSM RUN:
  - dec_ready = !clear_req.
  - inc_ready = !clear_req && !dec_valid. Decrement has priority and there is one write port, so at most one op is accepted per cycle.
  - clear_req in RUN → CLEAR next cycle. Any op already in stage 2 still completes its write and response.
  - overflow and underflow are cleared on the cycle CLEAR is entered.
  - clear_req outside RUN is ignored.
- Pipeline:
  - Cycle t: accept op and issue a registered RAM read of the node.
  - Cycle t+1 (stage 2): compute new = base ± 1. The result is written at the end of t+1.
  - For decrements, dec_resp_* is valid during t+1, a latency of 1.
- Forwarding:
  - If the stage-2 node equals the node written in the previous cycle by a valid op, base = that written value; otherwise base = RAM read data.
  - Every op therefore observes all earlier accepted ops, including the one immediately before it.
- Arithmetic:
  - Increment at max: stored value unchanged, overflow set.
  - Decrement at 0: stored value stays 0, resp degree 0, resp zero 1, underflow set.
  - No wrap-around ever.
- Idle: inputs are don't-care while !init_done, since ready is low.

Decomposition:
- Package indegree_pkg:
  - node_t and degree_t typedefs, parametrised via package parameters or a module-local typedef mirror.
  - Enum state_t {CLEAR, RUN}.
  - Enum op_t {OP_INC, OP_DEC}.
- One sub-module, degree_ram:
  - MAX_NODES x DEGREE_WIDTH, one write port and one registered read port, with no internal forwarding.
  - Forwarding, the FSM and the saturation logic live in indegree_table.

Test Plan:
- Reset release: count cycles → init_done rises after exactly 1024 cycles. Then dec node 5 → resp degree 0, zero=1, underflow=1.
- Three inc of node 7 on consecutive cycles, then dec 7 next cycle → resp node 7, degree 2, zero=0. This exercises back-to-back forwarding.
- inc 3 twice, then dec 3, dec 3 on consecutive cycles → resp degree 1 then 0 with zero=1 on the second.
- dec_valid and inc_valid in the same cycle (nodes 1 and 2) → inc_ready=0. inc is accepted the next cycle. Final degrees: node 1 = 0 with underflow, node 2 = 1.
- DEGREE_WIDTH=2: four inc of node 9 → overflow=1, stored 3. One dec → resp degree 2.
- Set node 4 to 2, pulse clear_req with a dec in flight → the in-flight response still appears. The table re-sweeps and overflow/underflow read 0. After init_done, dec 4 → degree 0 with underflow=1.
